// File: rtl/lc3b_fetch_queue_if.sv
// Fetch queue bus bundle: icache request/response, redirect, and decode dequeue.
//   master : the fetch queue (drives icache_addr/read and the deq_* head signals)
//   slave  : the environment (icache, branch unit, decode stage)
interface lc3b_fetch_queue_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);
  logic [ADDR_W-1:0] icache_addr;
  logic              icache_read;
  logic              icache_resp;
  logic [LINE_W-1:0] icache_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              deq_ready;
  logic              deq_valid;
  logic [15:0]       deq_instr;
  logic [ADDR_W-1:0] deq_pc;
  logic [ADDR_W-1:0] deq_next_pc;

  modport master (
    output icache_addr, icache_read, deq_valid, deq_instr, deq_pc, deq_next_pc,
    input  icache_resp, icache_rdata, redirect_valid, redirect_pc, deq_ready
  );

  modport slave (
    input  icache_addr, icache_read, deq_valid, deq_instr, deq_pc, deq_next_pc,
    output icache_resp, icache_rdata, redirect_valid, redirect_pc, deq_ready
  );
endinterface

// File: rtl/lc3b_fetch_queue.sv
// LC-3b instruction fetch unit with a small instruction queue.
// Fetches one 16-bit instruction per icache response, extracting the word
// addressed by the PC from the returned line, and queues {instr, pc} for decode.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   bus (master)  : icache_addr/read/resp/rdata, redirect_valid/pc,
//                   deq_ready/valid/instr/pc/next_pc
//   occupancy     : number of valid queue entries
// Optional build macro FETCH_PERF_EN adds perf_stall_cnt / perf_flush_cnt
// (saturating 32-bit counters of icache miss cycles and redirect cycles).
module lc3b_fetch_queue #(
  parameter int                ADDR_W   = 16,
  parameter int                LINE_W   = 128,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  lc3b_fetch_queue_if.master           bus,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                  perf_stall_cnt,
  output logic [31:0]                  perf_flush_cnt
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int WORDS = LINE_W / 16;

  typedef enum logic [1:0] {FETCH, FULL, SQUASH} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, tgt, tgt_nxt, redir_tgt;
  logic [15:0]       instr_q [DEPTH];
  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [CNT_W-1:0]  count;
  logic [15:0]       line_instr;
  logic              push, pop, flush;
  logic              unused_redir_lsb;

  // PCs are always halfword aligned; the target's LSB is dropped.
  assign redir_tgt        = {bus.redirect_pc[ADDR_W-1:1], 1'b0};
  assign unused_redir_lsb = bus.redirect_pc[0];

  generate
    if (WORDS > 1) begin : g_sel
      logic [$clog2(WORDS)-1:0] widx;
      assign widx       = pc[$clog2(WORDS):1];
      assign line_instr = bus.icache_rdata[16*widx +: 16];
    end else begin : g_one
      assign line_instr = bus.icache_rdata[15:0];
    end
  endgenerate

  assign flush           = bus.redirect_valid;
  assign bus.deq_valid   = (count != '0);
  // A redirect discards the same-cycle pop along with the queue contents.
  assign pop             = bus.deq_valid && bus.deq_ready && !flush;
  assign bus.icache_addr = pc;
  // Gated by rst so no request is visible while reset is held.
  assign bus.icache_read = !rst && (state != FULL);
  assign bus.deq_instr   = instr_q[rptr];
  assign bus.deq_pc      = pc_q[rptr];
  assign bus.deq_next_pc = pc_q[rptr] + ADDR_W'(2);
  assign occupancy       = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
      tgt   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      tgt   <= tgt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    tgt_nxt   = tgt;
    push      = 1'b0;
    case (state)
      FETCH: begin
        if (flush) begin
          if (bus.icache_resp) begin
            pc_nxt = redir_tgt;
          end else begin
            // Request still in flight: park the target until it returns.
            tgt_nxt   = redir_tgt;
            state_nxt = SQUASH;
          end
        end else if (bus.icache_resp) begin
          push   = 1'b1;
          pc_nxt = pc + ADDR_W'(2);
          if (!pop && count == CNT_W'(DEPTH-1)) state_nxt = FULL;
        end
      end
      FULL: begin
        if (flush) begin
          pc_nxt    = redir_tgt;
          state_nxt = FETCH;
        end else if (pop) begin
          state_nxt = FETCH;
        end
      end
      SQUASH: begin
        if (bus.icache_resp) begin
          pc_nxt    = flush ? redir_tgt : tgt;
          state_nxt = FETCH;
        end else if (flush) begin
          tgt_nxt = redir_tgt;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  // Payload storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wptr] <= line_instr;
      pc_q[wptr]    <= pc;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (bus.icache_read && !bus.icache_resp && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (bus.redirect_valid && perf_flush_cnt != '1)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_lc3b_fetch_queue.sv
// Self-checking bench for lc3b_fetch_queue: directed boundary cases followed
// by randomized traffic, scored against a queue-based reference model.
module tb_lc3b_fetch_queue;
  localparam int          ADDR_W   = 16;
  localparam int          LINE_W   = 128;
  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
  } item_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] occupancy;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  lc3b_fetch_queue_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus();

  lc3b_fetch_queue #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .occupancy(occupancy)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state
  item_t       m_q[$];
  logic [15:0] m_pc, m_sqt;
  bit          m_sq, m_stalled;
  int unsigned m_stall, m_flush;
  int          mode;
  bit          mon_en;
  int          checks, failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory image: mode 0 gives 16'h1000 + word index within the line,
  // mode 1 a per-address hash so any wrong word/line selection shows up.
  function automatic logic [15:0] word_of(input logic [15:0] a);
    if (mode == 0) return 16'h1000 + 16'((a % 16'(LINE_W/8)) / 16'd2);
    return 16'(a * 16'h9E37) ^ 16'hC3A5;
  endfunction

  function automatic logic [LINE_W-1:0] line_of(input logic [15:0] a);
    logic [LINE_W-1:0] l;
    logic [15:0]       base;
    base = a & ~16'(LINE_W/8 - 1);
    for (int i = 0; i < LINE_W/16; i++) l[i*16 +: 16] = word_of(base + 16'(2*i));
    return l;
  endfunction

  // One clock cycle: drive inputs, advance, then apply the model's effect.
  task automatic step(input bit resp, input bit ready, input bit redir, input logic [15:0] rpc);
    bit          r, pop;
    int          sz;
    logic [15:0] t;
    r  = resp && !m_stalled;
    sz = m_q.size();
    pop = (sz > 0) && ready && !redir;
    t  = {rpc[15:1], 1'b0};
    bus.icache_resp    = r;
    bus.icache_rdata   = line_of(m_pc);
    bus.deq_ready      = ready;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    if (!m_stalled && !r) m_stall++;
    if (redir) m_flush++;
    @(posedge clk);
    #2;
    if (redir) begin
      m_q.delete();
      if (m_sq) begin
        if (r) begin m_pc = t; m_sq = 0; end
        else m_sqt = t;
      end else if (m_stalled) begin
        m_pc = t; m_stalled = 0;
      end else if (r) begin
        m_pc = t;
      end else begin
        m_sq = 1; m_sqt = t;
      end
    end else if (m_sq) begin
      if (r) begin m_pc = m_sqt; m_sq = 0; end
    end else if (m_stalled) begin
      if (pop) m_stalled = 0;
    end else if (r) begin
      m_q.push_back('{instr: word_of(m_pc), pc: m_pc});
      if (!pop && sz + 1 == DEPTH) m_stalled = 1;
      m_pc = m_pc + 16'd2;
    end
  endtask

  task automatic do_reset();
    mon_en = 0;
    rst    = 1'b1;
    m_q.delete();
    m_pc = RESET_PC; m_sqt = '0; m_sq = 0; m_stalled = 0;
    m_stall = 0; m_flush = 0;
    @(negedge clk);
    chk("rst_read", {31'd0, bus.icache_read}, 32'd0);
    chk("rst_valid", {31'd0, bus.deq_valid}, 32'd0);
    chk("rst_occ", {29'd0, occupancy}, 32'd0);
    chk("rst_addr", {16'd0, bus.icache_addr}, {16'd0, RESET_PC});
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("read_after_rst", {31'd0, bus.icache_read}, 32'd1);
    mon_en = 1;
  endtask

  // Monitor: every cycle compare outputs against the model, and on each
  // model-predicted pop check the head entry against the scoreboard.
  always @(negedge clk) begin
    item_t it;
    if (mon_en) begin
      chk("icache_addr", {16'd0, bus.icache_addr}, {16'd0, m_pc});
      chk("icache_read", {31'd0, bus.icache_read}, {31'd0, !m_stalled});
      chk("deq_valid", {31'd0, bus.deq_valid}, {31'd0, m_q.size() != 0});
      chk("occupancy", {29'd0, occupancy}, 32'(m_q.size()));
      if (m_q.size() > 0 && bus.deq_ready && !bus.redirect_valid) begin
        it = m_q.pop_front();
        chk("deq_instr", {16'd0, bus.deq_instr}, {16'd0, it.instr});
        chk("deq_pc", {16'd0, bus.deq_pc}, {16'd0, it.pc});
        chk("deq_next_pc", {16'd0, bus.deq_next_pc}, {16'd0, 16'(it.pc + 16'd2)});
      end
    end
  end

  initial begin
    checks = 0; failures = 0; mode = 0; mon_en = 0;
    bus.icache_resp = 0; bus.icache_rdata = '0; bus.deq_ready = 0;
    bus.redirect_valid = 0; bus.redirect_pc = '0;

    // Streaming: response every cycle, decode always ready.
    do_reset();
    chk("first_valid_early", {31'd0, bus.deq_valid}, 32'd0);
    step(1, 1, 0, 0);
    chk("first_valid", {31'd0, bus.deq_valid}, 32'd1);
    chk("first_instr", {16'd0, bus.deq_instr}, 32'h1000);
    chk("first_pc", {16'd0, bus.deq_pc}, 32'h0000);
    step(1, 1, 0, 0);
    chk("second_instr", {16'd0, bus.deq_instr}, 32'h1001);
    chk("second_pc", {16'd0, bus.deq_pc}, 32'h0002);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0);

    // Fill to DEPTH, then one pop.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0);
    chk("full_occ", {29'd0, occupancy}, 32'd4);
    chk("full_read", {31'd0, bus.icache_read}, 32'd0);
    step(1, 1, 0, 0);
    chk("after_pop_occ", {29'd0, occupancy}, 32'd3);
    chk("after_pop_read", {31'd0, bus.icache_read}, 32'd1);

    // Redirect with the request outstanding -> squash the next response.
    step(0, 0, 1, 16'h0041);
    chk("squash_addr_held", {16'd0, bus.icache_addr}, 32'h0008);
    chk("squash_occ", {29'd0, occupancy}, 32'd0);
    step(1, 0, 0, 0);
    chk("squash_no_push", {29'd0, occupancy}, 32'd0);
    chk("squash_addr", {16'd0, bus.icache_addr}, 32'h0040);

    // Redirect coincident with response and pop at occupancy 2.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("occ2", {29'd0, occupancy}, 32'd2);
    step(1, 1, 1, 16'h0120);
    chk("redir_resp_occ", {29'd0, occupancy}, 32'd0);
    chk("redir_resp_valid", {31'd0, bus.deq_valid}, 32'd0);
    chk("redir_resp_addr", {16'd0, bus.icache_addr}, 32'h0120);

    // PC wrap at the top of the address space.
    step(1, 0, 1, 16'hFFFF);
    chk("wrap_addr_top", {16'd0, bus.icache_addr}, 32'hFFFE);
    step(1, 0, 0, 0);
    chk("wrap_addr", {16'd0, bus.icache_addr}, 32'h0000);
    chk("wrap_deq_pc", {16'd0, bus.deq_pc}, 32'hFFFE);
    chk("wrap_next_pc", {16'd0, bus.deq_next_pc}, 32'h0000);

    // Randomized traffic, with a reset landing on an outstanding request.
    mode = 1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        step(0, 1'($urandom_range(0, 1)), 0, 0);
        do_reset();
      end
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < ((i / 500) % 2 ? 30 : 80),
           $urandom_range(0, 99) < 4, 16'($urandom));
    end

`ifdef FETCH_PERF_EN
    chk("perf_stall", perf_stall_cnt, m_stall);
    chk("perf_flush", perf_flush_cnt, m_flush);
`endif

    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
